// File: rtl/csi_rx_packet_parser_if.sv
// Word-stream and decoded-output bundle between the CSI-2 word aligner, the packet parser
// and the downstream pixel unpacker.
interface csi_rx_packet_parser_if #(
    parameter int NUM_LANE = 2
);
    logic                  enable;
    logic [8*NUM_LANE-1:0] word_in;
    logic                  valid_in;

    logic                  packet_done;
    logic [5:0]            data_type;
    logic [1:0]            virtual_ch;
    logic [15:0]           word_count;
    logic [7:0]            header_ecc;
    logic                  frame_start;
    logic                  frame_end;
    logic                  line_start;
    logic                  line_end;
    logic [8*NUM_LANE-1:0] payload_out;
    logic [NUM_LANE-1:0]   payload_be;
    logic                  payload_valid;
    logic                  in_long_pkt;
    logic                  abort_err;

    modport master (
        output enable, word_in, valid_in,
        input  packet_done, data_type, virtual_ch, word_count, header_ecc,
               frame_start, frame_end, line_start, line_end,
               payload_out, payload_be, payload_valid, in_long_pkt, abort_err
    );

    modport slave (
        input  enable, word_in, valid_in,
        output packet_done, data_type, virtual_ch, word_count, header_ecc,
               frame_start, frame_end, line_start, line_end,
               payload_out, payload_be, payload_valid, in_long_pkt, abort_err
    );
endinterface

// File: rtl/csi_rx_packet_parser.sv
// CSI-2 packet parser: decodes headers, turns short sync packets into strobes and streams
// long-packet payload with per-lane byte enables, dropping the trailing CRC.
module csi_rx_packet_parser #(
    parameter int NUM_LANE = 2
) (
    input logic                   byte_clock,
    input logic                   reset_n,
    csi_rx_packet_parser_if.slave bus
);
    localparam int W = 8 * NUM_LANE;

    typedef enum logic [1:0] {IDLE, HDR2, PAYLOAD, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [16:0]     remaining_reg, remaining_next;
    logic [7:0]      di_reg, di_next;
    logic [7:0]      wcl_reg, wcl_next;

    logic            packet_done_reg, packet_done_next;
    logic [5:0]      data_type_reg, data_type_next;
    logic [1:0]      virtual_ch_reg, virtual_ch_next;
    logic [15:0]     word_count_reg, word_count_next;
    logic [7:0]      header_ecc_reg, header_ecc_next;
    logic            frame_start_reg, frame_start_next;
    logic            frame_end_reg, frame_end_next;
    logic            line_start_reg, line_start_next;
    logic            line_end_reg, line_end_next;
    logic [W-1:0]    payload_out_reg, payload_out_next;
    logic [NUM_LANE-1:0] payload_be_reg, payload_be_next;
    logic            payload_valid_reg, payload_valid_next;
    logic            in_long_pkt_reg, in_long_pkt_next;
    logic            abort_err_reg, abort_err_next;

    logic [7:0]      hdr_di, hdr_wcl, hdr_wcm, hdr_ecc;
    logic            hdr_accept;
    logic [16:0]     data_left;
    logic            last_word;
    logic [NUM_LANE-1:0] be_calc;

    // With 4 lanes the full header is in one word; with 2 lanes DI and WC_LSB were captured earlier.
    generate
        if (NUM_LANE == 4) begin : g_hdr4
            assign hdr_di  = bus.word_in[7:0];
            assign hdr_wcl = bus.word_in[15:8];
            assign hdr_wcm = bus.word_in[23:16];
            assign hdr_ecc = bus.word_in[31:24];
        end else begin : g_hdr2
            assign hdr_di  = di_reg;
            assign hdr_wcl = wcl_reg;
            assign hdr_wcm = bus.word_in[7:0];
            assign hdr_ecc = bus.word_in[15:8];
        end
    endgenerate

    // remaining counts payload plus the two CRC bytes, so the data still owed is remaining-2.
    assign data_left = (remaining_reg > 17'd2) ? (remaining_reg - 17'd2) : 17'd0;
    assign last_word = (remaining_reg <= 17'(NUM_LANE));

    generate
        for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_be
            assign be_calc[gi] = (data_left > 17'(gi));
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        remaining_next     = remaining_reg;
        di_next            = di_reg;
        wcl_next           = wcl_reg;
        data_type_next     = data_type_reg;
        virtual_ch_next    = virtual_ch_reg;
        word_count_next    = word_count_reg;
        header_ecc_next    = header_ecc_reg;
        payload_out_next   = payload_out_reg;
        payload_be_next    = payload_be_reg;
        in_long_pkt_next   = in_long_pkt_reg;
        abort_err_next     = abort_err_reg;
        packet_done_next   = 1'b0;
        frame_start_next   = 1'b0;
        frame_end_next     = 1'b0;
        line_start_next    = 1'b0;
        line_end_next      = 1'b0;
        payload_valid_next = 1'b0;
        hdr_accept         = 1'b0;

        if (bus.enable) begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid_in) begin
                        if (NUM_LANE == 4) begin
                            hdr_accept = 1'b1;
                        end else begin
                            di_next    = bus.word_in[7:0];
                            wcl_next   = bus.word_in[15:8];
                            state_next = HDR2;
                        end
                    end
                end
                HDR2: begin
                    if (bus.valid_in) begin
                        hdr_accept = 1'b1;
                    end else begin
                        packet_done_next = 1'b1;
                        abort_err_next   = 1'b1;
                        in_long_pkt_next = 1'b0;
                        state_next       = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (bus.valid_in) begin
                        payload_out_next   = bus.word_in;
                        payload_be_next    = be_calc;
                        payload_valid_next = (data_left != 17'd0);
                        if (last_word) begin
                            remaining_next   = 17'd0;
                            packet_done_next = 1'b1;
                            in_long_pkt_next = 1'b0;
                            state_next       = FLUSH;
                        end else begin
                            remaining_next = remaining_reg - 17'(NUM_LANE);
                        end
                    end else begin
                        remaining_next   = 17'd0;
                        packet_done_next = 1'b1;
                        abort_err_next   = 1'b1;
                        in_long_pkt_next = 1'b0;
                        state_next       = IDLE;
                    end
                end
                FLUSH: begin
                    if (!bus.valid_in) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (hdr_accept) begin
                data_type_next  = hdr_di[5:0];
                virtual_ch_next = hdr_di[7:6];
                word_count_next = {hdr_wcm, hdr_wcl};
                header_ecc_next = hdr_ecc;
                if (hdr_di[5:0] <= 6'h0F) begin
                    case (hdr_di[5:0])
                        6'h00:   frame_start_next = 1'b1;
                        6'h01:   frame_end_next   = 1'b1;
                        6'h02:   line_start_next  = 1'b1;
                        6'h03:   line_end_next    = 1'b1;
                        default: ;
                    endcase
                    packet_done_next = 1'b1;
                    state_next       = FLUSH;
                end else begin
                    remaining_next   = {1'b0, hdr_wcm, hdr_wcl} + 17'd2;
                    in_long_pkt_next = 1'b1;
                    state_next       = PAYLOAD;
                end
            end
        end
    end

    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            remaining_reg     <= '0;
            di_reg            <= '0;
            wcl_reg           <= '0;
            packet_done_reg   <= 1'b0;
            data_type_reg     <= '0;
            virtual_ch_reg    <= '0;
            word_count_reg    <= '0;
            header_ecc_reg    <= '0;
            frame_start_reg   <= 1'b0;
            frame_end_reg     <= 1'b0;
            line_start_reg    <= 1'b0;
            line_end_reg      <= 1'b0;
            payload_out_reg   <= '0;
            payload_be_reg    <= '0;
            payload_valid_reg <= 1'b0;
            in_long_pkt_reg   <= 1'b0;
            abort_err_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            remaining_reg     <= remaining_next;
            di_reg            <= di_next;
            wcl_reg           <= wcl_next;
            packet_done_reg   <= packet_done_next;
            data_type_reg     <= data_type_next;
            virtual_ch_reg    <= virtual_ch_next;
            word_count_reg    <= word_count_next;
            header_ecc_reg    <= header_ecc_next;
            frame_start_reg   <= frame_start_next;
            frame_end_reg     <= frame_end_next;
            line_start_reg    <= line_start_next;
            line_end_reg      <= line_end_next;
            payload_out_reg   <= payload_out_next;
            payload_be_reg    <= payload_be_next;
            payload_valid_reg <= payload_valid_next;
            in_long_pkt_reg   <= in_long_pkt_next;
            abort_err_reg     <= abort_err_next;
        end
    end

    assign bus.packet_done   = packet_done_reg;
    assign bus.data_type     = data_type_reg;
    assign bus.virtual_ch    = virtual_ch_reg;
    assign bus.word_count    = word_count_reg;
    assign bus.header_ecc    = header_ecc_reg;
    assign bus.frame_start   = frame_start_reg;
    assign bus.frame_end     = frame_end_reg;
    assign bus.line_start    = line_start_reg;
    assign bus.line_end      = line_end_reg;
    assign bus.payload_out   = payload_out_reg;
    assign bus.payload_be    = payload_be_reg;
    assign bus.payload_valid = payload_valid_reg;
    assign bus.in_long_pkt   = in_long_pkt_reg;
    assign bus.abort_err     = abort_err_reg;
endmodule

// File: tb/tb_csi_rx_packet_parser.sv
// Directed, table-driven bench for the CSI-2 packet parser in 2-lane and 4-lane builds.
module tb_csi_rx_packet_parser;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    csi_rx_packet_parser_if #(.NUM_LANE(2)) bus2 ();
    csi_rx_packet_parser_if #(.NUM_LANE(4)) bus4 ();

    csi_rx_packet_parser #(.NUM_LANE(2)) u_dut2 (.byte_clock(clk), .reset_n(reset_n), .bus(bus2));
    csi_rx_packet_parser #(.NUM_LANE(4)) u_dut4 (.byte_clock(clk), .reset_n(reset_n), .bus(bus4));

    typedef struct {
        logic        en, vld;
        logic [31:0] word;
        logic        done, pv;
        logic        cbe;
        logic [3:0]  be;
        logic        cpo;
        logic [31:0] pout;
        logic [3:0]  strb;   // {line_end, line_start, frame_end, frame_start}
        logic        inl, abrt;
        logic [5:0]  dt;
        logic [1:0]  vc;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } vec_t;

    vec_t v2[$];
    vec_t v4[$];

    function automatic vec_t mk(input logic en, vld, input logic [31:0] word,
                                input logic done, pv, cbe, input logic [3:0] be,
                                input logic cpo, input logic [31:0] pout, input logic [3:0] strb,
                                input logic inl, abrt, input logic [5:0] dt, input logic [1:0] vc,
                                input logic [15:0] wc, input logic [7:0] ecc);
        vec_t r;
        r.en = en; r.vld = vld; r.word = word; r.done = done; r.pv = pv; r.cbe = cbe;
        r.be = be; r.cpo = cpo; r.pout = pout; r.strb = strb; r.inl = inl; r.abrt = abrt;
        r.dt = dt; r.vc = vc; r.wc = wc; r.ecc = ecc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input int idx, input vec_t v,
                             input logic done, pv, input logic [3:0] be, input logic [31:0] pout,
                             input logic [3:0] strb, input logic inl, abrt, input logic [5:0] dt,
                             input logic [1:0] vc, input logic [15:0] wc, input logic [7:0] ecc);
        $display("[TB] %s row %0d: en=%0b vld=%0b word=%h -> done=%0b pv=%0b be=%b pout=%h strb=%b inl=%0b abort=%0b dt=%h vc=%0d wc=%h ecc=%h",
                 tag, idx, v.en, v.vld, v.word, done, pv, be, pout, strb, inl, abrt, dt, vc, wc, ecc);
        chk($sformatf("%s[%0d] packet_done", tag, idx), 32'(done), 32'(v.done));
        chk($sformatf("%s[%0d] payload_valid", tag, idx), 32'(pv), 32'(v.pv));
        chk($sformatf("%s[%0d] strobes", tag, idx), 32'(strb), 32'(v.strb));
        chk($sformatf("%s[%0d] in_long_pkt", tag, idx), 32'(inl), 32'(v.inl));
        chk($sformatf("%s[%0d] abort_err", tag, idx), 32'(abrt), 32'(v.abrt));
        chk($sformatf("%s[%0d] data_type", tag, idx), 32'(dt), 32'(v.dt));
        chk($sformatf("%s[%0d] virtual_ch", tag, idx), 32'(vc), 32'(v.vc));
        chk($sformatf("%s[%0d] word_count", tag, idx), 32'(wc), 32'(v.wc));
        chk($sformatf("%s[%0d] header_ecc", tag, idx), 32'(ecc), 32'(v.ecc));
        if (v.cbe) chk($sformatf("%s[%0d] payload_be", tag, idx), 32'(be), 32'(v.be));
        if (v.cpo) chk($sformatf("%s[%0d] payload_out", tag, idx), pout, v.pout);
    endtask

    task automatic run2(input vec_t v, input int idx);
        @(negedge clk);
        bus2.enable   = v.en;
        bus2.valid_in = v.vld;
        bus2.word_in  = v.word[15:0];
        @(posedge clk);
        #1;
        check_row("L2", idx, v, bus2.packet_done, bus2.payload_valid, {2'b00, bus2.payload_be},
                  {16'h0, bus2.payload_out},
                  {bus2.line_end, bus2.line_start, bus2.frame_end, bus2.frame_start},
                  bus2.in_long_pkt, bus2.abort_err, bus2.data_type, bus2.virtual_ch,
                  bus2.word_count, bus2.header_ecc);
    endtask

    task automatic run4(input vec_t v, input int idx);
        @(negedge clk);
        bus4.enable   = v.en;
        bus4.valid_in = v.vld;
        bus4.word_in  = v.word;
        @(posedge clk);
        #1;
        check_row("L4", idx, v, bus4.packet_done, bus4.payload_valid, bus4.payload_be,
                  bus4.payload_out,
                  {bus4.line_end, bus4.line_start, bus4.frame_end, bus4.frame_start},
                  bus4.in_long_pkt, bus4.abort_err, bus4.data_type, bus4.virtual_ch,
                  bus4.word_count, bus4.header_ecc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 2-lane: FS short packet, RAW8 WC=6, abort after 2 of 4 words, LE short, 3-cycle stall.
        v2.push_back(mk(1,1,'h0000, 0,0,0,0,0,0,     'b0000,0,0, 'h00,0,'h0000,'h00));
        v2.push_back(mk(1,1,'h5500, 1,0,0,0,0,0,     'b0001,0,0, 'h00,0,'h0000,'h55));
        v2.push_back(mk(1,1,'hAAAA, 0,0,0,0,0,0,     'b0000,0,0, 'h00,0,'h0000,'h55));
        v2.push_back(mk(1,0,'h0000, 0,0,0,0,0,0,     'b0000,0,0, 'h00,0,'h0000,'h55));
        v2.push_back(mk(1,1,'h066A, 0,0,0,0,0,0,     'b0000,0,0, 'h00,0,'h0000,'h55));
        v2.push_back(mk(1,1,'h3C00, 0,0,0,0,0,0,     'b0000,1,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,1,'h0201, 0,1,1,3,1,'h0201,'b0000,1,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,1,'h0403, 0,1,1,3,1,'h0403,'b0000,1,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,1,'h0605, 0,1,1,3,1,'h0605,'b0000,1,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,1,'hBEEF, 1,0,1,0,0,0,     'b0000,0,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,0,'h0000, 0,0,0,0,0,0,     'b0000,0,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,1,'h082B, 0,0,0,0,0,0,     'b0000,0,0, 'h2A,1,'h0006,'h3C));
        v2.push_back(mk(1,1,'h1200, 0,0,0,0,0,0,     'b0000,1,0, 'h2B,0,'h0008,'h12));
        v2.push_back(mk(1,1,'h1111, 0,1,1,3,1,'h1111,'b0000,1,0, 'h2B,0,'h0008,'h12));
        v2.push_back(mk(1,1,'h2222, 0,1,1,3,1,'h2222,'b0000,1,0, 'h2B,0,'h0008,'h12));
        v2.push_back(mk(1,0,'h0000, 1,0,0,0,0,0,     'b0000,0,1, 'h2B,0,'h0008,'h12));
        v2.push_back(mk(1,1,'h0003, 0,0,0,0,0,0,     'b0000,0,1, 'h2B,0,'h0008,'h12));
        v2.push_back(mk(1,1,'h0000, 1,0,0,0,0,0,     'b1000,0,1, 'h03,0,'h0000,'h00));
        v2.push_back(mk(1,0,'h0000, 0,0,0,0,0,0,     'b0000,0,1, 'h03,0,'h0000,'h00));
        v2.push_back(mk(1,1,'h042A, 0,0,0,0,0,0,     'b0000,0,1, 'h03,0,'h0000,'h00));
        v2.push_back(mk(1,1,'h0000, 0,0,0,0,0,0,     'b0000,1,1, 'h2A,0,'h0004,'h00));
        v2.push_back(mk(1,1,'hB2B1, 0,1,1,3,1,'hB2B1,'b0000,1,1, 'h2A,0,'h0004,'h00));
        for (int i = 0; i < 3; i++)
            v2.push_back(mk(0,0,'h0000, 0,0,1,3,1,'hB2B1,'b0000,1,1, 'h2A,0,'h0004,'h00));
        v2.push_back(mk(1,1,'hB4B3, 0,1,1,3,1,'hB4B3,'b0000,1,1, 'h2A,0,'h0004,'h00));
        v2.push_back(mk(1,1,'hCCCC, 1,0,1,0,0,0,     'b0000,0,1, 'h2A,0,'h0004,'h00));
        v2.push_back(mk(1,0,'h0000, 0,0,0,0,0,0,     'b0000,0,1, 'h2A,0,'h0004,'h00));

        // 4-lane: WC=5, FE short, WC=0 long, DT 0x08/0x0F short (no strobe), DT 0x10 long.
        v4.push_back(mk(1,1,'h770005AC, 0,0,0,0,0,0,           'b0000,1,0, 'h2C,2,'h0005,'h77));
        v4.push_back(mk(1,1,'h44332211, 0,1,1,'hF,1,'h44332211,'b0000,1,0, 'h2C,2,'h0005,'h77));
        v4.push_back(mk(1,1,'h00C2C155, 1,1,1,'h1,1,'h00C2C155,'b0000,0,0, 'h2C,2,'h0005,'h77));
        v4.push_back(mk(1,1,'hDEADBEEF, 0,0,0,0,0,0,           'b0000,0,0, 'h2C,2,'h0005,'h77));
        v4.push_back(mk(1,0,'h00000000, 0,0,0,0,0,0,           'b0000,0,0, 'h2C,2,'h0005,'h77));
        v4.push_back(mk(1,1,'h00000001, 1,0,0,0,0,0,           'b0010,0,0, 'h01,0,'h0000,'h00));
        v4.push_back(mk(1,0,'h00000000, 0,0,0,0,0,0,           'b0000,0,0, 'h01,0,'h0000,'h00));
        v4.push_back(mk(1,1,'h00000030, 0,0,0,0,0,0,           'b0000,1,0, 'h30,0,'h0000,'h00));
        v4.push_back(mk(1,1,'h0000ABCD, 1,0,1,0,0,0,           'b0000,0,0, 'h30,0,'h0000,'h00));
        v4.push_back(mk(1,0,'h00000000, 0,0,0,0,0,0,           'b0000,0,0, 'h30,0,'h0000,'h00));
        v4.push_back(mk(1,1,'h00000008, 1,0,0,0,0,0,           'b0000,0,0, 'h08,0,'h0000,'h00));
        v4.push_back(mk(1,0,'h00000000, 0,0,0,0,0,0,           'b0000,0,0, 'h08,0,'h0000,'h00));
        v4.push_back(mk(1,1,'h0000000F, 1,0,0,0,0,0,           'b0000,0,0, 'h0F,0,'h0000,'h00));
        v4.push_back(mk(1,0,'h00000000, 0,0,0,0,0,0,           'b0000,0,0, 'h0F,0,'h0000,'h00));
        v4.push_back(mk(1,1,'h00000010, 0,0,0,0,0,0,           'b0000,1,0, 'h10,0,'h0000,'h00));
        v4.push_back(mk(1,1,'h00000000, 1,0,1,0,0,0,           'b0000,0,0, 'h10,0,'h0000,'h00));
        v4.push_back(mk(1,0,'h00000000, 0,0,0,0,0,0,           'b0000,0,0, 'h10,0,'h0000,'h00));

        bus2.enable = 1'b1; bus2.valid_in = 1'b0; bus2.word_in = '0;
        bus4.enable = 1'b1; bus4.valid_in = 1'b0; bus4.word_in = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset packet_done L2", 32'(bus2.packet_done), 32'd0);
        chk("reset in_long_pkt L2", 32'(bus2.in_long_pkt), 32'd0);
        chk("reset abort_err L2", 32'(bus2.abort_err), 32'd0);
        chk("reset payload_be L2", 32'(bus2.payload_be), 32'd0);
        chk("reset payload_out L4", bus4.payload_out, 32'd0);
        chk("reset header L4", {bus4.virtual_ch, bus4.data_type, bus4.word_count, bus4.header_ecc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (v2[i]) run2(v2[i], i);
        foreach (v4[i]) run4(v4[i], i);

        // Asynchronous reset in the middle of a payload, then an LS packet with valid held high.
        run2(mk(1,1,'h062A, 0,0,0,0,0,0,     'b0000,0,1, 'h2A,0,'h0004,'h00), 100);
        run2(mk(1,1,'h0000, 0,0,0,0,0,0,     'b0000,1,1, 'h2A,0,'h0006,'h00), 101);
        run2(mk(1,1,'h1234, 0,1,1,3,1,'h1234,'b0000,1,1, 'h2A,0,'h0006,'h00), 102);
        #2;
        reset_n = 1'b0;
        bus2.word_in  = 16'h0002;
        bus2.valid_in = 1'b1;
        #1;
        $display("[TB] async reset: pv=%0b be=%b pout=%h inl=%0b abort=%0b dt=%h wc=%h",
                 bus2.payload_valid, bus2.payload_be, bus2.payload_out, bus2.in_long_pkt,
                 bus2.abort_err, bus2.data_type, bus2.word_count);
        chk("async reset payload_valid", 32'(bus2.payload_valid), 32'd0);
        chk("async reset payload_be", 32'(bus2.payload_be), 32'd0);
        chk("async reset payload_out", 32'(bus2.payload_out), 32'd0);
        chk("async reset in_long_pkt", 32'(bus2.in_long_pkt), 32'd0);
        chk("async reset abort_err", 32'(bus2.abort_err), 32'd0);
        chk("async reset data_type", 32'(bus2.data_type), 32'd0);
        chk("async reset word_count", 32'(bus2.word_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] post-reset header word: done=%0b ls=%0b", bus2.packet_done, bus2.line_start);
        chk("post-reset first word packet_done", 32'(bus2.packet_done), 32'd0);
        chk("post-reset first word line_start", 32'(bus2.line_start), 32'd0);
        run2(mk(1,1,'h0000, 1,0,0,0,0,0, 'b0100,0,0, 'h02,0,'h0000,'h00), 103);
        run2(mk(1,0,'h0000, 0,0,0,0,0,0, 'b0000,0,0, 'h02,0,'h0000,'h00), 104);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
